alu_seq: RTL and testbench

//  Parametrised, handshaked ALU: single-cycle ops plus iterative unsigned multiply/divide.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshaked operation/result bundle between the EX stage and alu_seq.
// master drives ops, flush and out_ready; slave (the ALU) returns results and flags.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             neg;
  logic             over;
  logic             illegal;

  modport master (
    output flush, in_valid, alu_op, port_a, port_b, out_ready,
    input  in_ready, out_valid, out, zero, neg, over, illegal
  );

  modport slave (
    input  flush, in_valid, alu_op, port_a, port_b, out_ready,
    output in_ready, out_valid, out, zero, neg, over, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus iterative unsigned MUL/DIV.
// Define ALU_SEQ_MULDIV_EN to build the iterative datapath; otherwise ops 10-13 report illegal.
//
// state | meaning
// IDLE  | no result held, ready for an op
// BUSY  | MUL/DIV iterating, one step per cycle (ALU_SEQ_MULDIV_EN only)
// DONE  | result and flags held until out_ready
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     CLK,
  input  logic     nRST,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic {IDLE, DONE} state_t;
`endif

  state_t           state;
  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q, neg_q, over_q, ill_q;

  logic [WIDTH-1:0] res_c, sum_c, dif_c;
  logic             over_c, ill_c;
  logic [SW-1:0]    shamt;
  logic             accept;

  assign bus.in_ready  = !bus.flush && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.over      = over_q;
  assign bus.illegal   = ill_q;

  assign shamt = bus.port_b[SW-1:0];
  assign sum_c = bus.port_a + bus.port_b;
  assign dif_c = bus.port_a - bus.port_b;

`ifdef ALU_SEQ_MULDIV_EN
  logic                 iter_c;
  logic [SW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, acc_nxt, mul_nxt, div_nxt;
  logic [WIDTH-1:0]     opnd, fin;
  logic [WIDTH:0]       mul_sum, div_dif;
  logic                 is_div, sel_hi, div_ok;

  // acc holds {hi, lo} of the product, or {remainder, quotient-in-progress} for divide
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    div_dif = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, opnd};
    div_ok  = acc[2*WIDTH-1] || !div_dif[WIDTH];
    div_nxt = div_ok ? {div_dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                     : {acc[2*WIDTH-2:0], 1'b0};
    acc_nxt = is_div ? div_nxt : mul_nxt;
    fin     = sel_hi ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
  end
`endif

  always_comb begin
    res_c  = '0;
    over_c = 1'b0;
    ill_c  = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    iter_c = 1'b0;
`endif
    case (bus.alu_op)
      4'd0:  res_c = bus.port_a << shamt;
      4'd1:  res_c = bus.port_a >> shamt;
      4'd2: begin
        res_c  = sum_c;
        over_c = (bus.port_a[WIDTH-1] == bus.port_b[WIDTH-1]) &&
                 (sum_c[WIDTH-1] != bus.port_a[WIDTH-1]);
      end
      4'd3: begin
        res_c  = dif_c;
        over_c = (bus.port_a[WIDTH-1] != bus.port_b[WIDTH-1]) &&
                 (dif_c[WIDTH-1] != bus.port_a[WIDTH-1]);
      end
      4'd4:  res_c = bus.port_a & bus.port_b;
      4'd5:  res_c = bus.port_a | bus.port_b;
      4'd6:  res_c = bus.port_a ^ bus.port_b;
      4'd7:  res_c = ~(bus.port_a | bus.port_b);
      4'd8:  res_c = {{(WIDTH-1){1'b0}}, $signed(bus.port_a) < $signed(bus.port_b)};
      4'd9:  res_c = {{(WIDTH-1){1'b0}}, bus.port_a < bus.port_b};
      4'd10, 4'd11, 4'd12, 4'd13: begin
`ifdef ALU_SEQ_MULDIV_EN
        iter_c = 1'b1;
`else
        ill_c  = 1'b1;
`endif
      end
      4'd14: res_c = $signed(bus.port_a) >>> shamt;
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      over_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      sel_hi  <= 1'b0;
`endif
    end else if (bus.flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
    end else if (accept) begin
`ifdef ALU_SEQ_MULDIV_EN
      if (iter_c) begin
        state   <= BUSY;
        valid_q <= 1'b0;
        acc     <= {{WIDTH{1'b0}}, bus.port_a};
        opnd    <= bus.port_b;
        is_div  <= bus.alu_op[2];
        sel_hi  <= bus.alu_op[0];
        cnt     <= SW'(WIDTH-1);
      end else
`endif
      begin
        state   <= DONE;
        valid_q <= 1'b1;
        out_q   <= res_c;
        zero_q  <= (res_c == '0);
        neg_q   <= res_c[WIDTH-1];
        over_q  <= over_c;
        ill_q   <= ill_c;
      end
    end else begin
      case (state)
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          acc <= acc_nxt;
          if (cnt == '0) begin
            state   <= DONE;
            valid_q <= 1'b1;
            out_q   <= fin;
            zero_q  <= (fin == '0);
            neg_q   <= fin[WIDTH-1];
            over_q  <= 1'b0;
            ill_q   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        DONE: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against a transaction-level reference model.
// Honours ALU_SEQ_MULDIV_EN the same way as the design.
module tb_alu_seq;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int checks = 0;
  int errors = 0;

  bit          m_have = 0;
  int          m_busy = 0;
  logic [31:0] m_out  = '0;
  bit          m_over = 0, m_ill = 0;
  bit          last_acc = 0;

  bit          lit_on = 0;
  logic [31:0] lit_out;
  bit          lit_zero, lit_over, lit_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_iter(input logic [3:0] op);
`ifdef ALU_SEQ_MULDIV_EN
    return op >= 4'd10 && op <= 4'd13;
`else
    return 1'b0;
`endif
  endfunction

  // returns {illegal, over, result}
  function automatic logic [33:0] ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        r;
    logic signed [31:0] sa;
    logic [63:0]        p;
    bit                 ov, il;
    r = '0; ov = 0; il = 0; sa = a;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  r = a << b[4:0];
      4'd1:  r = a >> b[4:0];
      4'd2:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd3:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a | b);
      4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  r = (a < b) ? 32'd1 : 32'd0;
      4'd14: r = sa >>> b[4:0];
      default: il = 1;
    endcase
    if (is_iter(op)) begin
      il = 0;
      case (op)
        4'd10:   r = p[31:0];
        4'd11:   r = p[63:32];
        4'd12:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return {il, ov, r};
  endfunction

  function automatic bit exp_ready();
    return !bus.flush && (!m_have || (m_busy == 0 && bus.out_ready));
  endfunction

  task automatic compare();
    chk("in_ready", 32'(bus.in_ready), 32'(nRST ? exp_ready() : 1'b1));
    chk("out_valid", 32'(bus.out_valid), 32'(m_have && m_busy == 0));
    if (!nRST) begin
      chk("rst_out", bus.out, 32'd0);
      chk("rst_flags", {28'd0, bus.zero, bus.neg, bus.over, bus.illegal}, 32'd0);
    end else if (m_have && m_busy == 0) begin
      chk("out", bus.out, m_out);
      chk("zero", 32'(bus.zero), 32'(m_out == 0));
      chk("neg", 32'(bus.neg), 32'(m_out[31]));
      chk("over", 32'(bus.over), 32'(m_over));
      chk("illegal", 32'(bus.illegal), 32'(m_ill));
    end
    if (lit_on && bus.out_valid) begin
      chk("lit_out", bus.out, lit_out);
      chk("lit_zero", 32'(bus.zero), 32'(lit_zero));
      chk("lit_over", 32'(bus.over), 32'(lit_over));
      chk("lit_illegal", 32'(bus.illegal), 32'(lit_ill));
      lit_on = 0;
    end
  endtask

  task automatic model_update();
    logic [33:0] r;
    bit          acc;
    last_acc = 0;
    if (!nRST) begin
      m_have = 0; m_busy = 0;
    end else if (bus.flush) begin
      m_have = 0; m_busy = 0;
    end else begin
      acc = bus.in_valid && exp_ready();
      if (m_have && m_busy > 0) m_busy--;
      else if (m_have && bus.out_ready) m_have = 0;
      if (acc) begin
        r      = ref_calc(bus.alu_op, bus.port_a, bus.port_b);
        m_have = 1;
        m_busy = is_iter(bus.alu_op) ? W : 0;
        m_out  = r[31:0];
        m_over = r[32];
        m_ill  = r[33];
        last_acc = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    compare();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic drain();
    bus.out_ready = 1; bus.in_valid = 0; bus.flush = 0;
    for (int i = 0; i < 40 && m_have; i++) tick();
    chk("drained", 32'(m_have), 32'd0);
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eo, input bit ez, input bit eov, input bit eil, input int elat);
    int lat;
    drain();
    bus.alu_op = op; bus.port_a = a; bus.port_b = b; bus.in_valid = 1;
    tick();
    chk("accept", 32'(last_acc), 32'd1);
    bus.in_valid = 0; bus.port_a = $urandom; bus.port_b = $urandom;
    lit_out = eo; lit_zero = ez; lit_over = eov; lit_ill = eil; lit_on = 1;
    lat = 0;
    while (lit_on && lat < 60) begin tick(); lat++; end
    chk("lit_done", 32'(lit_on), 32'd0);
    lit_on = 0;
    chk("latency", 32'(lat), 32'(elat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op;
    bus.flush = 0; bus.in_valid = 0; bus.alu_op = '0;
    bus.port_a = '0; bus.port_b = '0; bus.out_ready = 1;
    #2;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    tick(); tick();
    nRST = 1;
    tick();

    send(4'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, 1);
    send(4'd3, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 0, 1);
    send(4'd8, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, 0, 0, 1);
    send(4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 1);
    send(4'd14, 32'h8000_0000, 32'd4, 32'hF800_0000, 0, 0, 0, 1);
    send(4'd0, 32'h1, 32'd33, 32'h2, 0, 0, 0, 1);
    send(4'd15, 32'h5, 32'h6, 32'h0, 1, 0, 1, 1);
`ifdef ALU_SEQ_MULDIV_EN
    send(4'd11, 32'h0001_0000, 32'h0001_0000, 32'h1, 0, 0, 0, W + 1);
    send(4'd10, 32'h0001_0000, 32'h0001_0000, 32'h0, 1, 0, 0, W + 1);
    send(4'd12, 32'd7, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, W + 1);
    send(4'd13, 32'd7, 32'd0, 32'd7, 0, 0, 0, W + 1);
    send(4'd12, 32'd100, 32'd7, 32'd14, 0, 0, 0, W + 1);
    send(4'd13, 32'd100, 32'd7, 32'd2, 0, 0, 0, W + 1);
`else
    send(4'd10, 32'd3, 32'd5, 32'h0, 1, 0, 1, 1);
    send(4'd12, 32'd100, 32'd7, 32'h0, 1, 0, 1, 1);
`endif

    // back-to-back single-cycle ops
    drain();
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0: op = 4'd3;
        1: op = 4'd4;
        default: op = 4'd8;
      endcase
      bus.alu_op = op; bus.port_a = pick(); bus.port_b = pick(); bus.in_valid = 1;
      tick();
      chk("stream_acc", 32'(last_acc), 32'd1);
    end
    bus.in_valid = 0;
    tick();

    // held result, then accept on release
    drain();
    bus.alu_op = 4'd2; bus.port_a = 32'd40; bus.port_b = 32'd2; bus.in_valid = 1; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out", bus.out, 32'd42);
    end
    bus.alu_op = 4'd5; bus.port_a = 32'hF0; bus.port_b = 32'h0F; bus.in_valid = 1; bus.out_ready = 1;
    tick();
    chk("hold_acc", 32'(last_acc), 32'd1);
    bus.in_valid = 0;
    tick();

`ifdef ALU_SEQ_MULDIV_EN
    // flush in the middle of a divide
    drain();
    bus.alu_op = 4'd12; bus.port_a = 32'd1000; bus.port_b = 32'd3; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 10; i++) tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("flush_rdy", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 40; i++) tick();
    op = 4'd11;
`else
    op = 4'd2;
`endif

    // asynchronous reset while an op is in flight
    drain();
    bus.alu_op = op; bus.port_a = 32'hFFFF_FFFF; bus.port_b = 32'hFFFF_FFFF;
    bus.in_valid = 1; bus.out_ready = 0;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    nRST = 0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out", bus.out, 32'd0);
    chk("arst_flags", {28'd0, bus.zero, bus.neg, bus.over, bus.illegal}, 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    m_have = 0; m_busy = 0;
    bus.out_ready = 1;
    tick(); tick();
    nRST = 1;
    for (int i = 0; i < 40; i++) tick();

    for (int i = 0; i < 1500; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.alu_op    = 4'($urandom_range(0, 15));
      bus.port_a    = pick();
      bus.port_b    = pick();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    for (int i = 0; i < 40; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
